// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: trap CSRs, 64-bit mcycle/minstret counters,
// combinational EX read port and continuous views for the interrupt arbiter.
module csr_regfile #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MHARTID     = 32'd0,
  parameter int          EN_COUNTERS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_we_i,
  input  logic [31:0] ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [31:0] ex_raddr_i,
  output logic [31:0] ex_rdata_o,
  input  logic        clint_we_i,
  input  logic [31:0] clint_waddr_i,
  input  logic [31:0] clint_wdata_i,
  input  logic        instret_i,
  output logic [31:0] csr_mtvec_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mstatus_o,
  output logic [31:0] csr_mie_o,
  output logic        global_int_en_o
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MHARTID   = 12'hF14;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [31:0] MIE_MASK    = 32'h0000_0888;

  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic [31:0] r_mie;
  logic [31:2] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:2] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;

  logic        w_we;
  logic [11:0] w_waddr;
  logic [31:0] w_wdata;
  logic [31:0] w_mstatus;
  logic [63:0] w_mcycle;
  logic [63:0] w_minstret;
  logic        w_unused;

  // Single write port: the arbiter always wins over EX
  always_comb begin
    if (clint_we_i) begin
      w_we    = 1'b1;
      w_waddr = clint_waddr_i[11:0];
      w_wdata = clint_wdata_i;
    end else begin
      w_we    = ex_we_i;
      w_waddr = ex_waddr_i[11:0];
      w_wdata = ex_wdata_i;
    end
  end

  // Trap CSR state; only legal fields are stored
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= 32'd0;
      r_mtvec        <= MTVEC_RESET[31:2];
      r_mscratch     <= 32'd0;
      r_mepc         <= 30'd0;
      r_mcause       <= 32'd0;
      r_mtval        <= 32'd0;
    end else if (w_we) begin
      case (w_waddr)
        A_MSTATUS: begin
          r_mstatus_mie  <= w_wdata[3];
          r_mstatus_mpie <= w_wdata[7];
        end
        A_MIE:      r_mie      <= w_wdata & MIE_MASK;
        A_MTVEC:    r_mtvec    <= w_wdata[31:2];
        A_MSCRATCH: r_mscratch <= w_wdata;
        A_MEPC:     r_mepc     <= w_wdata[31:2];
        A_MCAUSE:   r_mcause   <= w_wdata;
        A_MTVAL:    r_mtval    <= w_wdata;
        default: begin
        end
      endcase
    end
  end

  // Counters: a half-write replaces that cycle's increment; carry only on increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcycle   <= 64'd0;
      r_minstret <= 64'd0;
    end else if (EN_COUNTERS != 0) begin
      if (w_we && (w_waddr == A_MCYCLE)) begin
        r_mcycle[31:0] <= w_wdata;
      end else if (w_we && (w_waddr == A_MCYCLEH)) begin
        r_mcycle[63:32] <= w_wdata;
      end else begin
        r_mcycle <= r_mcycle + 64'd1;
      end
      if (w_we && (w_waddr == A_MINSTRET)) begin
        r_minstret[31:0] <= w_wdata;
      end else if (w_we && (w_waddr == A_MINSTRETH)) begin
        r_minstret[63:32] <= w_wdata;
      end else if (instret_i) begin
        r_minstret <= r_minstret + 64'd1;
      end else begin
        r_minstret <= r_minstret;
      end
    end else begin
      r_mcycle   <= 64'd0;
      r_minstret <= 64'd0;
    end
  end

  assign w_mstatus  = {19'd0, 2'b11, 3'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
  assign w_mcycle   = (EN_COUNTERS != 0) ? r_mcycle   : 64'd0;
  assign w_minstret = (EN_COUNTERS != 0) ? r_minstret : 64'd0;
  assign w_unused   = ^{ex_waddr_i[31:12], ex_raddr_i[31:12], clint_waddr_i[31:12]};

  // EX read mux; unmapped addresses read as zero
  always_comb begin
    ex_rdata_o = 32'd0;
    case (ex_raddr_i[11:0])
      A_MSTATUS:                ex_rdata_o = w_mstatus;
      A_MIE:                    ex_rdata_o = r_mie;
      A_MTVEC:                  ex_rdata_o = {r_mtvec, 2'b00};
      A_MSCRATCH:               ex_rdata_o = r_mscratch;
      A_MEPC:                   ex_rdata_o = {r_mepc, 2'b00};
      A_MCAUSE:                 ex_rdata_o = r_mcause;
      A_MTVAL:                  ex_rdata_o = r_mtval;
      A_MHARTID:                ex_rdata_o = MHARTID;
      A_MCYCLE,    A_CYCLE:     ex_rdata_o = w_mcycle[31:0];
      A_MCYCLEH,   A_CYCLEH:    ex_rdata_o = w_mcycle[63:32];
      A_MINSTRET,  A_INSTRET:   ex_rdata_o = w_minstret[31:0];
      A_MINSTRETH, A_INSTRETH:  ex_rdata_o = w_minstret[63:32];
      default:                  ex_rdata_o = 32'd0;
    endcase
  end

  assign csr_mtvec_o     = {r_mtvec, 2'b00};
  assign csr_mepc_o      = {r_mepc, 2'b00};
  assign csr_mstatus_o   = w_mstatus;
  assign csr_mie_o       = r_mie;
  assign global_int_en_o = r_mstatus_mie;

endmodule
